// File: rtl/sdram_pattern_tester.sv
// Purpose: SDRAM self-test. Writes a pattern to NUM_WORDS consecutive words,
//          reads them back, then reports err_count, first_err_addr, pass and timeout.
// Latency: each access is one req/ack handshake; every output is registered.
// Backpressure: a command is held stable until fpga_ack is seen. Each wait is
//          bounded by TIMEOUT_CYCLES, after which the test aborts to DONE.
// Ports:   fpga_clk/fpga_reset (sync, active-high); start/mode/seed start a test;
//          fpga_addr/fpga_wr_en/fpga_rd_en/fpga_wr_data/fpga_req/fpga_ack form the
//          command handshake; fpga_rd_data/fpga_data_ready return read data;
//          busy/done/pass/timeout/err_count/first_err_addr report status.
module sdram_pattern_tester #(
   parameter int unsigned                 FPGA_ADDR_WIDTH = 23,
   parameter int unsigned                 FPGA_DATA_WIDTH = 32,
   parameter logic [FPGA_ADDR_WIDTH-1:0]  START_ADDR      = '0,
   parameter int unsigned                 NUM_WORDS       = 1024,
   parameter int unsigned                 ERR_CNT_WIDTH   = 16,
   parameter int unsigned                 TIMEOUT_CYCLES  = 255
) (
   input  logic                        fpga_clk,
   input  logic                        fpga_reset,
   input  logic                        start,
   input  logic [1:0]                  mode,
   input  logic [FPGA_DATA_WIDTH-1:0]  seed,
   output logic [FPGA_ADDR_WIDTH-1:0]  fpga_addr,
   output logic                        fpga_wr_en,
   output logic                        fpga_rd_en,
   output logic [FPGA_DATA_WIDTH-1:0]  fpga_wr_data,
   output logic                        fpga_req,
   input  logic                        fpga_ack,
   input  logic [FPGA_DATA_WIDTH-1:0]  fpga_rd_data,
   input  logic                        fpga_data_ready,
   output logic                        busy,
   output logic                        done,
   output logic                        pass,
   output logic                        timeout,
   output logic [ERR_CNT_WIDTH-1:0]    err_count,
   output logic [FPGA_ADDR_WIDTH-1:0]  first_err_addr
);

   localparam int unsigned IDX_W  = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
   localparam int unsigned WAIT_W = $clog2(TIMEOUT_CYCLES + 2);

   localparam logic [IDX_W-1:0]         LAST_IDX = IDX_W'(NUM_WORDS - 1);
   localparam logic [IDX_W-1:0]         IDX_ONE  = IDX_W'(1);
   localparam logic [WAIT_W-1:0]        WAIT_MAX = WAIT_W'(TIMEOUT_CYCLES);
   localparam logic [WAIT_W-1:0]        WAIT_ONE = WAIT_W'(1);
   localparam logic [ERR_CNT_WIDTH-1:0] ERR_ONE  = ERR_CNT_WIDTH'(1);
   localparam logic [FPGA_DATA_WIDTH-1:0] DATA_ONE = FPGA_DATA_WIDTH'(1);

   typedef enum logic [2:0] {
      IDLE, WR_REQ, WR_REL, RD_REQ, RD_WAIT, RD_REL, DONE
   } state_t;

   state_t                       state_q, state_d;
   logic [IDX_W-1:0]             idx_q, idx_d;
   logic [WAIT_W-1:0]            wait_q, wait_d;
   logic [1:0]                   mode_q, mode_d;
   logic [FPGA_DATA_WIDTH-1:0]   seed_q, seed_d;
   logic [FPGA_ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic [FPGA_DATA_WIDTH-1:0]   wr_data_q, wr_data_d;
   logic                         req_q, req_d;
   logic                         wr_en_q, wr_en_d;
   logic                         rd_en_q, rd_en_d;
   logic                         busy_q, busy_d;
   logic                         done_q, done_d;
   logic                         pass_q, pass_d;
   logic                         timeout_q, timeout_d;
   logic [ERR_CNT_WIDTH-1:0]     err_q, err_d;
   logic [FPGA_ADDR_WIDTH-1:0]   first_err_q, first_err_d;
   logic                         cmp_en;
   logic [FPGA_DATA_WIDTH-1:0]   exp_rd;

   // Pattern word for a given index.
   function automatic logic [FPGA_DATA_WIDTH-1:0] pattern(
      input logic [1:0]                 m,
      input logic [FPGA_DATA_WIDTH-1:0] s,
      input logic [IDX_W-1:0]           i
   );
      logic [FPGA_DATA_WIDTH-1:0] ext;
      ext = FPGA_DATA_WIDTH'(i);
      case (m)
         2'd0:    pattern = ext;
         2'd1:    pattern = DATA_ONE << (32'(i) % FPGA_DATA_WIDTH);
         2'd2:    pattern = s + ext;
         default: pattern = i[0] ? ~s : s;
      endcase
   endfunction

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      mode_d      = mode_q;
      seed_d      = seed_q;
      err_d       = err_q;
      first_err_d = first_err_q;
      timeout_d   = timeout_q;
      pass_d      = pass_q;
      cmp_en      = 1'b0;

      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               mode_d      = mode;
               seed_d      = seed;
               err_d       = '0;
               first_err_d = '0;
               timeout_d   = 1'b0;
               pass_d      = 1'b0;
               idx_d       = '0;
               state_d     = WR_REQ;
            end
         end
         WR_REQ: begin
            if (fpga_ack)                state_d = WR_REL;
            else if (wait_q == WAIT_MAX) begin state_d = DONE; timeout_d = 1'b1; end
         end
         WR_REL: begin
            if (!fpga_ack) begin
               if (idx_q < LAST_IDX) begin idx_d = idx_q + IDX_ONE; state_d = WR_REQ; end
               else                  begin idx_d = '0;              state_d = RD_REQ; end
            end else if (wait_q == WAIT_MAX) begin
               state_d = DONE; timeout_d = 1'b1;
            end
         end
         RD_REQ: begin
            // Data may come back in the same cycle as the ack; take it directly.
            if (fpga_ack) begin
               if (fpga_data_ready) begin cmp_en = 1'b1; state_d = RD_REL; end
               else                 state_d = RD_WAIT;
            end else if (wait_q == WAIT_MAX) begin
               state_d = DONE; timeout_d = 1'b1;
            end
         end
         RD_WAIT: begin
            if (fpga_data_ready)         begin cmp_en = 1'b1; state_d = RD_REL; end
            else if (wait_q == WAIT_MAX) begin state_d = DONE; timeout_d = 1'b1; end
         end
         RD_REL: begin
            if (!fpga_ack) begin
               if (idx_q < LAST_IDX) begin idx_d = idx_q + IDX_ONE; state_d = RD_REQ; end
               else                  state_d = DONE;
            end else if (wait_q == WAIT_MAX) begin
               state_d = DONE; timeout_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

      // The counter saturates, so err_q==0 identifies the first mismatch.
      exp_rd = pattern(mode_q, seed_q, idx_q);
      if (cmp_en && (fpga_rd_data != exp_rd)) begin
         if (err_q == '0) first_err_d = addr_q;
         if (err_q != '1) err_d = err_q + ERR_ONE;
      end

      if ((state_d == DONE) && (state_q != DONE))
         pass_d = (err_d == '0) && !timeout_d;

      // Counts cycles spent in the current busy state; zero on any transition.
      if ((state_d == state_q) && (state_q != IDLE) && (state_q != DONE))
         wait_d = wait_q + WAIT_ONE;
      else
         wait_d = '0;

      // Outputs are derived from the next state so they can be registered.
      req_d     = (state_d == WR_REQ) || (state_d == RD_REQ);
      wr_en_d   = (state_d == WR_REQ);
      rd_en_d   = (state_d == RD_REQ);
      wr_data_d = (state_d == WR_REQ) ? pattern(mode_d, seed_d, idx_d) : '0;
      addr_d    = ((state_d == WR_REQ) || (state_d == RD_REQ))
                  ? START_ADDR + FPGA_ADDR_WIDTH'(idx_d) : addr_q;
      busy_d    = (state_d != IDLE) && (state_d != DONE);
      done_d    = (state_d == DONE);
   end

   always_ff @(posedge fpga_clk) begin
      if (fpga_reset) begin
         state_q     <= IDLE;
         idx_q       <= '0;
         wait_q      <= '0;
         mode_q      <= '0;
         seed_q      <= '0;
         addr_q      <= '0;
         wr_data_q   <= '0;
         req_q       <= 1'b0;
         wr_en_q     <= 1'b0;
         rd_en_q     <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         pass_q      <= 1'b0;
         timeout_q   <= 1'b0;
         err_q       <= '0;
         first_err_q <= '0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         wait_q      <= wait_d;
         mode_q      <= mode_d;
         seed_q      <= seed_d;
         addr_q      <= addr_d;
         wr_data_q   <= wr_data_d;
         req_q       <= req_d;
         wr_en_q     <= wr_en_d;
         rd_en_q     <= rd_en_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         pass_q      <= pass_d;
         timeout_q   <= timeout_d;
         err_q       <= err_d;
         first_err_q <= first_err_d;
      end
   end

   assign fpga_addr      = addr_q;
   assign fpga_wr_en     = wr_en_q;
   assign fpga_rd_en     = rd_en_q;
   assign fpga_wr_data   = wr_data_q;
   assign fpga_req       = req_q;
   assign busy           = busy_q;
   assign done           = done_q;
   assign pass           = pass_q;
   assign timeout        = timeout_q;
   assign err_count      = err_q;
   assign first_err_addr = first_err_q;

endmodule
